lsu_req_rsp: RTL

//  Parametrised, multi-cycle load-store unit with a valid/ready request and response handshake.

---
 rtl/lsu_req_rsp.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_req_rsp.sv
// lsu_req_rsp: multi-cycle load-store unit with valid/ready request and response.
// Decodes DMEM, output-register channels and synchronised input channels.
module lsu_req_rsp #(
    parameter int unsigned DMEM_BYTES  = 2048,
    parameter logic [31:0] OUT_BASE    = 32'h1000_7000,
    parameter int unsigned N_OUT       = 5,
    parameter logic [31:0] IN_BASE     = 32'h1001_7800,
    parameter int unsigned N_IN        = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wren,
    input  logic [2:0]            i_req_funct3,
    input  logic [31:0]           i_req_addr,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_rdata,
    output logic [1:0]            o_rsp_err,
    output logic [N_OUT*32-1:0]   o_io_out,
    input  logic [N_IN*32-1:0]    i_io_in
);

    localparam int unsigned WORDS = DMEM_BYTES / 4;
    localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic                 wren_q, wren_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rsp_rdata_q, rsp_rdata_d;
    logic [1:0]           rsp_err_q, rsp_err_d;
    logic [N_OUT*32-1:0]  io_out_q, io_out_d;
    logic [N_IN*32-1:0]   sync_q [SYNC_STAGES];
    logic [N_IN*32-1:0]   sync_d [SYNC_STAGES];

    logic [31:0]          dmem [WORDS];

    logic                 dmem_hit, out_hit, in_hit;
    logic [27:0]          out_off, in_off;
    logic                 illegal, misalign;
    logic [1:0]           err;
    logic [3:0]           be;
    logic [31:0]          wrep;
    logic [31:0]          rd_word, lane, ld_data;
    logic [IW-1:0]        dmem_idx;
    logic                 dmem_we;

    // Address decode, error classification, lane enables and load extraction.
    always_comb begin
        dmem_hit = addr_q < 32'(DMEM_BYTES);
        dmem_idx = IW'((addr_q >> 2) & 32'(WORDS - 1));
        out_off  = addr_q[31:4] - OUT_BASE[31:4];
        in_off   = addr_q[31:4] - IN_BASE[31:4];
        out_hit  = (out_off < 28'(N_OUT)) && (addr_q[3:2] == 2'b00);
        in_hit   = (in_off < 28'(N_IN)) && (addr_q[3:2] == 2'b00);
        illegal  = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11)
                   || (wren_q && funct3_q[2]);
        misalign = ((funct3_q[1:0] == 2'b01) && addr_q[0])
                   || ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        if (illegal)
            err = 2'b11;
        else if (misalign)
            err = 2'b01;
        else if (!(dmem_hit || out_hit || (in_hit && !wren_q)))
            err = 2'b10;
        else
            err = 2'b00;

        case (funct3_q[1:0])
            2'b00: begin
                be   = 4'b0001 << addr_q[1:0];
                wrep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata_q[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wrep = wdata_q;
            end
        endcase

        rd_word = '0;
        if (dmem_hit) begin
            rd_word = dmem[dmem_idx];
        end else if (out_hit) begin
            for (int k = 0; k < int'(N_OUT); k++)
                if (out_off == 28'(k))
                    rd_word = io_out_q[32*k +: 32];
        end else if (in_hit) begin
            for (int k = 0; k < int'(N_IN); k++)
                if (in_off == 28'(k))
                    rd_word = sync_q[SYNC_STAGES-1][32*k +: 32];
        end

        lane = rd_word >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {24'd0, lane[7:0]};
            3'b101:  ld_data = {16'd0, lane[15:0]};
            default: ld_data = '0;
        endcase
    end

    // FSM next state, request capture, response and output-channel updates.
    always_comb begin
        state_d     = state_q;
        wren_d      = wren_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        io_out_d    = io_out_q;
        dmem_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    state_d  = S_ACCESS;
                    wren_d   = i_req_wren;
                    funct3_d = i_req_funct3;
                    addr_d   = i_req_addr;
                    wdata_d  = i_req_wdata;
                end
            end
            S_ACCESS: begin
                state_d     = S_RESP;
                rsp_err_d   = err;
                rsp_rdata_d = (err == 2'b00 && !wren_q) ? ld_data : '0;
                if (err == 2'b00 && wren_q) begin
                    if (dmem_hit) begin
                        dmem_we = 1'b1;
                    end else if (out_hit) begin
                        for (int k = 0; k < int'(N_OUT); k++)
                            if (out_off == 28'(k))
                                for (int b = 0; b < 4; b++)
                                    if (be[b])
                                        io_out_d[32*k+8*b +: 8] = wrep[8*b +: 8];
                    end
                end
            end
            S_RESP: begin
                if (i_rsp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Input synchroniser chain: stage 0 samples the raw asynchronous inputs.
    always_comb begin
        sync_d[0] = i_io_in;
        for (int s = 1; s < int'(SYNC_STAGES); s++)
            sync_d[s] = sync_q[s-1];
    end

    // State, request, response, output and synchroniser registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            wren_q      <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= '0;
            io_out_q    <= '0;
            for (int s = 0; s < int'(SYNC_STAGES); s++)
                sync_q[s] <= '0;
        end else begin
            state_q     <= state_d;
            wren_q      <= wren_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            io_out_q    <= io_out_d;
            for (int s = 0; s < int'(SYNC_STAGES); s++)
                sync_q[s] <= sync_d[s];
        end
    end

    // DMEM byte-lane write; contents survive reset, but reset blocks a pending write.
    always_ff @(posedge i_clk) begin
        if (dmem_we && !i_reset)
            for (int b = 0; b < 4; b++)
                if (be[b])
                    dmem[dmem_idx][8*b +: 8] <= wrep[8*b +: 8];
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_rsp_valid = (state_q == S_RESP);
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_io_out    = io_out_q;

endmodule
